mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_stall;

  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;
  logic        ls_ack;
  logic [31:0] ls_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        err;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata, mem_ack,
    output if_ack, if_rdata, if_stall, ls_ack, ls_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, err
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata, mem_ack,
    input  if_ack, if_rdata, if_stall, ls_ack, ls_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-port memory,
// one access at a time, with load/store priority bounded by a starvation counter.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GNT_IF = 2'd1;
  localparam logic [1:0] GNT_LS = 2'd2;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [1:0]  state_q, state_d;
  logic [2:0]  starve_cnt_q, starve_cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        if_ack_q, if_ack_d;
  logic        ls_ack_q, ls_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        err_q, err_d;
  logic        ls_wins;

  // Load/store wins unless a waiting fetch has already been passed over LIMIT times.
  assign ls_wins = bus.ls_req && (!bus.if_req || (starve_cnt_q < LIMIT));

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    if_ack_d     = 1'b0;
    ls_ack_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (bus.mem_ack) begin
          err_d = 1'b1;
        end
        if (ls_wins) begin
          state_d = GNT_LS;
          we_d    = bus.ls_we;
          addr_d  = bus.ls_addr;
          wdata_d = bus.ls_we ? bus.ls_wdata : 32'h0;
          be_d    = bus.ls_we ? bus.ls_be : 4'hF;
          if (bus.if_req && (starve_cnt_q < LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
          end
        end else if (bus.if_req) begin
          state_d      = GNT_IF;
          we_d         = 1'b0;
          addr_d       = bus.if_addr;
          wdata_d      = 32'h0;
          be_d         = 4'hF;
          starve_cnt_d = 3'd0;
        end
      end
      GNT_IF: begin
        if (bus.mem_ack) begin
          if_rdata_d = bus.mem_rdata;
          if_ack_d   = 1'b1;
          state_d    = IDLE;
        end
      end
      GNT_LS: begin
        if (bus.mem_ack) begin
          ls_rdata_d = we_q ? 32'h0 : bus.mem_rdata;
          ls_ack_d   = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 3'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      be_q         <= 4'h0;
      if_ack_q     <= 1'b0;
      ls_ack_q     <= 1'b0;
      if_rdata_q   <= 32'h0;
      ls_rdata_q   <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      if_ack_q     <= if_ack_d;
      ls_ack_q     <= ls_ack_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
      err_q        <= err_d;
    end
  end

  // The latched request is only exposed while a grant is active, so the bus reads 0 in IDLE.
  logic granted;
  assign granted = (state_q != IDLE);

  assign bus.mem_req   = granted;
  assign bus.mem_we    = granted & we_q;
  assign bus.mem_addr  = granted ? addr_q  : 32'h0;
  assign bus.mem_wdata = granted ? wdata_q : 32'h0;
  assign bus.mem_be    = granted ? be_q    : 4'h0;

  assign bus.if_ack   = if_ack_q;
  assign bus.ls_ack   = ls_ack_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.err      = err_q;
  assign bus.if_stall = bus.if_req & ~if_ack_q;

endmodule
